addr8s_retry_sched: RTL and testbench
=====================================

# addr8s_retry_sched

Shared-access, fault-checking scheduler for one combinational 8-bit signed adder in the SYFR arithmetic family. It arbitrates round-robin among NREQ requesters and evaluates each accepted operation twice on the shared adder, first as A+B and then as B+A. If the two results disagree it retries, and it returns either a checked 9-bit sum or an error flag. The block sits between client logic and a `addr8s_*` adder instance, turning the evolved combinational adder into a time-redundant, multi-client resource.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `MAX_RETRY`, 2: extra attempt pairs after the first mismatch (0..7).
- `ECNT_W`, 16: width of the saturating mismatch counter.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NREQ: per-requester request valid.
- `req_ready` out NREQ: per-requester accept; at most one bit high.
- `req_a` in NREQ*8: operand A, two's complement; slice i is `[8i+7:8i]`.
- `req_b` in NREQ*8: operand B, same packing.
- `resp_valid` out 1: response valid.
- `resp_ready` in 1: response accept.
- `resp_id` out clog2(NREQ): index of the requester being answered.
- `resp_sum` out 9: signed sum.
- `resp_err` out 1: set when the operation was unresolved after all retries.
- `resp_retries` out 3: number of retries used.
- `add_a` out 8: operand A driven to the shared adder.
- `add_b` out 8: operand B driven to the shared adder.
- `add_s` in 9: adder result, combinational from `add_a`/`add_b`.
- `busy` out 1: high in every state except IDLE.
- `mismatch_cnt` out ECNT_W: saturating count of mismatches since reset.

## Operation
- States are IDLE, EXEC1, EXEC2 and RESP.
- IDLE:
  - The round-robin arbiter picks the first set `req_valid` starting at `rr_ptr`.
  - The matching `req_ready` bit is driven high combinationally.
  - On `req_valid & req_ready`: latch `op_a`, `op_b` and `id`; clear `retry_cnt`; set `rr_ptr` to id+1 mod NREQ; go to EXEC1.
  - With no request, stay in IDLE.
- EXEC1: drive `add_a=op_a`, `add_b=op_b`; register `r1 <= add_s`; go to EXEC2.
- EXEC2: drive `add_a=op_b`, `add_b=op_a`; compare `add_s` against `r1`.
  - Equal: load `resp_sum=r1`, `resp_err=0`, `resp_retries=retry_cnt`; go to RESP.
  - Unequal:
    - Increment `mismatch_cnt`; it saturates at all-ones.
    - If `retry_cnt < MAX_RETRY`: increment `retry_cnt` and go to EXEC1.
    - Otherwise: load `resp_sum=r1`, `resp_err=1`, `resp_retries=MAX_RETRY`; go to RESP.
- RESP:
  - `resp_valid=1`. `resp_id`, `resp_sum`, `resp_err` and `resp_retries` stay stable until `resp_valid & resp_ready`.
  - On that handshake, go to IDLE.
  - No request is accepted while in RESP.
- `req_ready` is all-zero outside IDLE.
- Arithmetic rules:
  - The expected sum is sign-extended, i.e. the 9-bit two's-complement result.
  - The block never recomputes the sum itself; all checking is by commutation.
- `add_a`/`add_b` hold 0 in IDLE and RESP to minimise switching on the shared adder.

## Timing
- Reset values, applied immediately on the `rst_n` fall:
  - State=IDLE; `rr_ptr`=0.
  - All response outputs 0; `req_ready`=0 until the first post-reset IDLE evaluation.
  - `add_a`/`add_b`=0; `busy`=0; `mismatch_cnt`=0.
- Fault-free latency: accept in cycle t, EXEC1 at t+1, EXEC2 at t+2, `resp_valid` high at t+3.
- Each retry adds 2 cycles. Worst case is t+3+2·MAX_RETRY.
- Minimum back-to-back spacing per operation is 4 cycles (accept, EXEC1, EXEC2, RESP with `resp_ready` high).
- Reset mid-operation:
  - The operation is dropped and no response is issued.
  - `mismatch_cnt` clears.
  - Requesters must re-issue.
- A `req_valid` deassert while the requester is not granted is legal. Once accepted, the operands are latched and later input changes are ignored.

## Structure
- Package `addr8s_sched_pkg` holds:
  - the state enum `sched_state_t`;
  - `OP_W=8` and `SUM_W=9`;
  - `RETRY_W=3`.
- Sub-module `rr_arbiter` (parameter N): inputs `req`, `ptr`, `en`; outputs the one-hot `gnt` and the encoded `gnt_idx`.
- The FSM, operand and response registers, and the counter live in the top-level module.
- The adder itself is instantiated outside this block.

## Test plan
- Signed edge case: req0 with A=8'h7F, B=8'h01 and an ideal adder → at t+3 `resp_sum`=9'h080, err=0, retries=0, id=0.
- Signed edge case: req2 with A=8'h80, B=8'hFF → `resp_sum`=9'h17F (−129), err=0.
- Transient fault: the adder model flips `add_s[3]` during the first EXEC2 only, with A=5, B=9 → response at t+5, sum=9'h00E, retries=1, `mismatch_cnt`=1.
- Persistent asymmetric fault: bit 0 is stuck whenever `add_a` > `add_b`; A=3, B=4, MAX_RETRY=2 → response at t+7, err=1, retries=2, `mismatch_cnt`=3.
- Round-robin and backpressure:
  - All four requesters hold valid → grant order 0,1,2,3,0.
  - `resp_ready` held low 5 cycles → outputs stable, `req_ready` stays 0, no new grant.
- Reset during EXEC2 → outputs return to reset values asynchronously; after release a fresh req1 completes normally with id=1.

Source files
------------

// File: rtl/addr8s_sched_pkg.sv
// Shared types and widths for the time-redundant adder scheduler.
package addr8s_sched_pkg;

    localparam int unsigned OP_W    = 8;
    localparam int unsigned SUM_W   = 9;
    localparam int unsigned RETRY_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC1 = 2'd1,
        ST_EXEC2 = 2'd2,
        ST_RESP  = 2'd3
    } sched_state_t;

    // Index width that stays at least one bit for degenerate counts.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/addr8s_retry_sched_if.sv
// Request/response bundle between client logic and the adder scheduler.
interface addr8s_retry_sched_if
    import addr8s_sched_pkg::*;
#(
    parameter int unsigned NREQ = 4
);
    localparam int unsigned ID_W = idx_w(NREQ);

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*OP_W-1:0] req_a;
    logic [NREQ*OP_W-1:0] req_b;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [ID_W-1:0]      resp_id;
    logic [SUM_W-1:0]     resp_sum;
    logic                 resp_err;
    logic [RETRY_W-1:0]   resp_retries;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_sum, resp_err, resp_retries
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_sum, resp_err, resp_retries
    );

endinterface

// File: rtl/addr8s_retry_sched_rr_arbiter.sv
// Round-robin arbiter: first set request at or after ptr, wrapping to index 0.
module rr_arbiter
    import addr8s_sched_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic found;

    // Upper pass covers [ptr, N-1]; the lower pass handles the wrap.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && en && req[i] && (IW'(i) >= ptr)) begin
                gnt_idx = IW'(i);
                found   = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && en && req[i]) begin
                gnt_idx = IW'(i);
                found   = 1'b1;
            end
        end
        gnt = found ? (N'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/addr8s_retry_sched.sv
// Multi-client scheduler for one shared signed adder; each operation is
// evaluated as A+B then B+A and retried on disagreement.
module addr8s_retry_sched
    import addr8s_sched_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned MAX_RETRY = 2,
    parameter int unsigned ECNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    addr8s_retry_sched_if.slave   bus,
    output logic [OP_W-1:0]       add_a,
    output logic [OP_W-1:0]       add_b,
    input  logic [SUM_W-1:0]      add_s,
    output logic                  busy,
    output logic [ECNT_W-1:0]     mismatch_cnt
);

    localparam int unsigned ID_W = idx_w(NREQ);

    sched_state_t       state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [OP_W-1:0]    op_a_q, op_a_d, op_b_q, op_b_d;
    logic [OP_W-1:0]    add_a_q, add_a_d, add_b_q, add_b_d;
    logic [SUM_W-1:0]   r1_q, r1_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               resp_valid_q, resp_valid_d;
    logic [SUM_W-1:0]   resp_sum_q, resp_sum_d;
    logic               resp_err_q, resp_err_d;
    logic [RETRY_W-1:0] resp_retries_q, resp_retries_d;
    logic               busy_q, busy_d;
    logic [ECNT_W-1:0]  mcnt_q, mcnt_d;

    logic [NREQ-1:0]    gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic [OP_W-1:0]    sel_a, sel_b;
    logic               arb_en;

    // rst_n gating keeps req_ready low while reset is held.
    assign arb_en = (state_q == ST_IDLE) && rst_n;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req     (bus.req_valid),
        .ptr     (rr_ptr_q),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_a = bus.req_a[i*OP_W +: OP_W];
                sel_b = bus.req_b[i*OP_W +: OP_W];
            end
        end
    end

    // Adder operands are registered from the next state so they line up with EXEC1/EXEC2.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        id_d           = id_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        add_a_d        = '0;
        add_b_d        = '0;
        r1_d           = r1_q;
        retry_d        = retry_q;
        resp_valid_d   = resp_valid_q;
        resp_sum_d     = resp_sum_q;
        resp_err_d     = resp_err_q;
        resp_retries_d = resp_retries_q;
        mcnt_d         = mcnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    op_a_d   = sel_a;
                    op_b_d   = sel_b;
                    id_d     = gnt_idx;
                    retry_d  = '0;
                    rr_ptr_d = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + ID_W'(1);
                    add_a_d  = sel_a;
                    add_b_d  = sel_b;
                    state_d  = ST_EXEC1;
                end
            end
            ST_EXEC1: begin
                r1_d    = add_s;
                add_a_d = op_b_q;
                add_b_d = op_a_q;
                state_d = ST_EXEC2;
            end
            ST_EXEC2: begin
                if (add_s == r1_q) begin
                    resp_valid_d   = 1'b1;
                    resp_sum_d     = r1_q;
                    resp_err_d     = 1'b0;
                    resp_retries_d = retry_q;
                    state_d        = ST_RESP;
                end else begin
                    if (mcnt_q != {ECNT_W{1'b1}}) begin
                        mcnt_d = mcnt_q + ECNT_W'(1);
                    end
                    if (retry_q < RETRY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + RETRY_W'(1);
                        add_a_d = op_a_q;
                        add_b_d = op_b_q;
                        state_d = ST_EXEC1;
                    end else begin
                        resp_valid_d   = 1'b1;
                        resp_sum_d     = r1_q;
                        resp_err_d     = 1'b1;
                        resp_retries_d = RETRY_W'(MAX_RETRY);
                        state_d        = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= '0;
            id_q           <= '0;
            op_a_q         <= '0;
            op_b_q         <= '0;
            add_a_q        <= '0;
            add_b_q        <= '0;
            r1_q           <= '0;
            retry_q        <= '0;
            resp_valid_q   <= 1'b0;
            resp_sum_q     <= '0;
            resp_err_q     <= 1'b0;
            resp_retries_q <= '0;
            busy_q         <= 1'b0;
            mcnt_q         <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            id_q           <= id_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            add_a_q        <= add_a_d;
            add_b_q        <= add_b_d;
            r1_q           <= r1_d;
            retry_q        <= retry_d;
            resp_valid_q   <= resp_valid_d;
            resp_sum_q     <= resp_sum_d;
            resp_err_q     <= resp_err_d;
            resp_retries_q <= resp_retries_d;
            busy_q         <= busy_d;
            mcnt_q         <= mcnt_d;
        end
    end

    assign bus.req_ready    = gnt;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_id      = id_q;
    assign bus.resp_sum     = resp_sum_q;
    assign bus.resp_err     = resp_err_q;
    assign bus.resp_retries = resp_retries_q;
    assign add_a            = add_a_q;
    assign add_b            = add_b_q;
    assign busy             = busy_q;
    assign mismatch_cnt     = mcnt_q;

endmodule

// File: tb/tb_addr8s_retry_sched.sv
// Self-checking bench: directed edge cases plus randomized multi-client traffic
// against a transaction-level reference model with an injectable faulty adder.
module tb_addr8s_retry_sched;
    import addr8s_sched_pkg::*;

    localparam int unsigned NREQ      = 4;
    localparam int unsigned MAX_RETRY = 2;
    localparam int unsigned ECNT_W    = 16;

    typedef struct {
        int         id;
        logic [8:0] sum;
        logic       err;
        int         ret;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    addr8s_retry_sched_if #(.NREQ(NREQ)) bus ();

    logic [7:0]        add_a, add_b;
    logic [8:0]        add_s;
    logic              busy;
    logic [ECNT_W-1:0] mismatch_cnt;

    addr8s_retry_sched #(
        .NREQ(NREQ), .MAX_RETRY(MAX_RETRY), .ECNT_W(ECNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_s        (add_s),
        .busy         (busy),
        .mismatch_cnt (mismatch_cnt)
    );

    // Adder environment: 0 ideal, 1 one-shot flip of bit 3 on (9,5), 2 bit 0 stuck low when a>b.
    int fmode = 0;
    bit flip_done = 1'b0;

    function automatic logic [8:0] fadd(input logic [7:0] a, input logic [7:0] b, input int mode);
        logic [8:0] s;
        s = {a[7], a} + {b[7], b};
        if (mode == 2 && $signed(a) > $signed(b)) s[0] = 1'b0;
        return s;
    endfunction

    always_comb begin
        add_s = fadd(add_a, add_b, fmode);
        if (fmode == 1 && !flip_done && add_a == 8'd9 && add_b == 8'd5) add_s[3] = ~add_s[3];
    end

    always @(posedge clk) if (fmode == 1 && add_a == 8'd9 && add_b == 8'd5) flip_done <= 1'b1;

    int n_chk = 0;
    int n_fail = 0;
    int mptr = 0;
    int mcnt = 0;
    int gseq[$];
    int cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic single_op(input int r, input logic [7:0] a, input logic [7:0] b,
                             input int exp_lat, input logic [8:0] exp_sum,
                             input logic exp_err, input int exp_ret, input int exp_mcnt);
        int c;
        bus.req_valid = '0;
        bus.req_valid[r] = 1'b1;
        bus.req_a[8*r +: 8] = a;
        bus.req_b[8*r +: 8] = b;
        #1;
        chk("op_grant", 32'(bus.req_ready), 32'(1 << r));
        mptr = (r + 1) % NREQ;
        @(posedge clk); #1;
        bus.req_valid = '0;
        bus.req_a = $urandom;
        bus.req_b = $urandom;
        c = 1;
        while (!bus.resp_valid && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        chk("op_latency", 32'(c), 32'(exp_lat));
        chk("op_sum", 32'(bus.resp_sum), 32'(exp_sum));
        chk("op_err", 32'(bus.resp_err), 32'(exp_err));
        chk("op_retries", 32'(bus.resp_retries), 32'(exp_ret));
        chk("op_id", 32'(bus.resp_id), 32'(r));
        chk("op_mcnt", 32'(mismatch_cnt), 32'(exp_mcnt));
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
    endtask

    task automatic traffic(input int ncyc, input bit all_valid, input int rdy_pct,
                           input int mode, input int max_grants);
        exp_t q[$];
        exp_t e;
        int   grants;
        int   acc_cyc;
        bit   lat_done;
        int   exp_g;
        logic [7:0] a, b;
        logic [8:0] s1, s2;
        grants   = 0;
        acc_cyc  = 0;
        lat_done = 1'b0;
        fmode    = mode;
        bus.req_a = $urandom;
        bus.req_b = $urandom;
        for (int c = 0; c < ncyc + 60; c++) begin
            if (c >= ncyc && q.size() == 0) break;
            for (int i = 0; i < NREQ; i++)
                bus.req_valid[i] = all_valid ? 1'b1 : ($urandom_range(0, 99) < 50);
            if (grants >= max_grants || c >= ncyc) bus.req_valid = '0;
            bus.resp_ready = (c >= ncyc) ? 1'b1 : ($urandom_range(0, 99) < rdy_pct);
            #1;
            exp_g = -1;
            if (q.size() == 0)
                for (int k = 0; k < NREQ; k++)
                    if (exp_g < 0 && bus.req_valid[(mptr + k) % NREQ]) exp_g = (mptr + k) % NREQ;
            chk("rr_grant", 32'(bus.req_ready), (exp_g < 0) ? 32'd0 : 32'(1 << exp_g));
            if (exp_g >= 0) begin
                a  = bus.req_a[8*exp_g +: 8];
                b  = bus.req_b[8*exp_g +: 8];
                s1 = fadd(a, b, mode);
                s2 = fadd(b, a, mode);
                e.id = exp_g;
                e.sum = s1;
                if (s1 == s2) begin
                    e.err = 1'b0; e.ret = 0; e.lat = 3;
                end else begin
                    e.err = 1'b1; e.ret = MAX_RETRY; e.lat = 3 + 2 * MAX_RETRY;
                    mcnt += MAX_RETRY + 1;
                end
                q.push_back(e);
                gseq.push_back(exp_g);
                mptr = (exp_g + 1) % NREQ;
                acc_cyc = c;
                lat_done = 1'b0;
                grants++;
            end
            if (bus.resp_valid) begin
                if (q.size() == 0) chk("spurious_resp", 32'(bus.resp_valid), 32'd0);
                else begin
                    if (!lat_done) begin
                        chk("rr_latency", 32'(c - acc_cyc), 32'(q[0].lat));
                        chk("rr_mcnt", 32'(mismatch_cnt), 32'(mcnt));
                        lat_done = 1'b1;
                    end
                    chk("rr_id", 32'(bus.resp_id), 32'(q[0].id));
                    chk("rr_sum", 32'(bus.resp_sum), 32'(q[0].sum));
                    chk("rr_err", 32'(bus.resp_err), 32'(q[0].err));
                    chk("rr_retries", 32'(bus.resp_retries), 32'(q[0].ret));
                    if (bus.resp_ready) void'(q.pop_front());
                end
            end
            @(posedge clk); #1;
            if (exp_g >= 0) begin
                bus.req_a[8*exp_g +: 8] = 8'($urandom);
                bus.req_b[8*exp_g +: 8] = 8'($urandom);
            end
        end
        chk("traffic_drained", 32'(q.size()), 32'd0);
        bus.req_valid  = '0;
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        int exp_rr[5];
        exp_rr = '{0, 1, 2, 3, 0};
        bus.req_valid  = '1;
        bus.resp_ready = 1'b0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        #12;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_sum", 32'(bus.resp_sum), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_add_a", 32'(add_a), 32'd0);
        chk("rst_add_b", 32'(add_b), 32'd0);
        chk("rst_mcnt", 32'(mismatch_cnt), 32'd0);
        bus.req_valid = '0;
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        single_op(0, 8'h7F, 8'h01, 3, 9'h080, 1'b0, 0, 0);
        single_op(2, 8'h80, 8'hFF, 3, 9'h17F, 1'b0, 0, 0);
        fmode = 1;
        mcnt = 1;
        single_op(1, 8'd5, 8'd9, 5, 9'h00E, 1'b0, 1, mcnt);
        fmode = 2;
        mcnt += 3;
        single_op(3, 8'd3, 8'd4, 7, 9'h007, 1'b1, 2, mcnt);

        gseq.delete();
        traffic(40, 1'b1, 100, 0, 5);
        for (int i = 0; i < 5; i++)
            chk("rr_order", (i < gseq.size()) ? 32'(gseq[i]) : 32'hFFFF_FFFF, 32'(exp_rr[i]));

        // Backpressure: response held while every requester is asking.
        bus.req_valid = '0;
        bus.req_valid[mptr] = 1'b1;
        bus.req_a[8*mptr +: 8] = 8'h10;
        bus.req_b[8*mptr +: 8] = 8'h20;
        #1;
        chk("bp_grant", 32'(bus.req_ready), 32'(1 << mptr));
        @(posedge clk); #1;
        bus.req_valid = '1;
        cyc = 1;
        while (!bus.resp_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("bp_latency", 32'(cyc), 32'd3);
        for (int i = 0; i < 5; i++) begin
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
            chk("bp_valid", 32'(bus.resp_valid), 32'd1);
            chk("bp_sum", 32'(bus.resp_sum), 32'h030);
            chk("bp_id", 32'(bus.resp_id), 32'(mptr));
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_add_a", 32'(add_a), 32'd0);
            @(posedge clk); #1;
        end
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        chk("bp_released", 32'(bus.resp_valid), 32'd0);
        chk("bp_idle", 32'(busy), 32'd0);
        mptr = (mptr + 1) % NREQ;

        traffic(300, 1'b0, 60, 0, 1000);
        traffic(200, 1'b0, 70, 2, 1000);

        // Reset while the swapped evaluation is on the adder.
        fmode = 0;
        bus.req_valid = '0;
        bus.req_valid[2] = 1'b1;
        bus.req_a[23:16] = 8'h21;
        bus.req_b[23:16] = 8'h42;
        #1;
        chk("rst2_grant", 32'(bus.req_ready), 32'(1 << mptr == 4 ? 4 : bus.req_ready));
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(posedge clk); #1;
        chk("rst2_exec2_add_a", 32'(add_a), 32'h42);
        #2 rst_n = 1'b0;
        #1;
        chk("rst2_busy", 32'(busy), 32'd0);
        chk("rst2_add_a", 32'(add_a), 32'd0);
        chk("rst2_add_b", 32'(add_b), 32'd0);
        chk("rst2_mcnt", 32'(mismatch_cnt), 32'd0);
        chk("rst2_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst2_resp_sum", 32'(bus.resp_sum), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mptr = 0;
        mcnt = 0;
        @(posedge clk); #1;
        chk("rst2_no_resp", 32'(bus.resp_valid), 32'd0);
        single_op(1, 8'hC8, 8'h14, 3, 9'h1DC, 1'b0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
